singleport_ram_writer: RTL

//  Write-side companion of the single-port ROM read sequencer: on start_w, accepts DEPTH words over a

---
 rtl/ram_rw_pkg.sv | 15 +
 rtl/singleport_ram_writer.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/ram_rw_pkg.sv
// rtl/ram_rw_pkg.sv - state encoding and default geometry shared by the RAM writer and ROM read sequencer
package ram_rw_pkg;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] WRITE  = 3'd1;
  localparam logic [2:0] FLUSH  = 3'd2;
  localparam logic [2:0] VERIFY = 3'd3;
  localparam logic [2:0] CHECK  = 3'd4;
  localparam logic [2:0] FIN    = 3'd5;

  localparam int DATA_W_DEF = 16;
  localparam int DEPTH_DEF  = 100;
  localparam int ADDR_W_DEF = 7;

endpackage

// File: rtl/singleport_ram_writer.sv
// rtl/singleport_ram_writer.sv - streams DEPTH words into a single-port RAM; optional readback checksum (RAM_WRITER_VERIFY_EN)
module singleport_ram_writer
  import ram_rw_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_w,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              busy,
  output logic              done,
  output logic              verify_err,
  output logic              mem_ena,
  output logic              mem_wea,
  output logic [ADDR_W-1:0] mem_addra,
  output logic [DATA_W-1:0] mem_dina,
  input  logic [DATA_W-1:0] mem_douta
);

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_done;
  logic              r_verify_err;
  logic              r_mem_ena;
  logic              r_mem_wea;
  logic [ADDR_W-1:0] r_mem_addra;
  logic [DATA_W-1:0] r_mem_dina;
  logic [DATA_W-1:0] r_chk_w;

  logic w_beat;
  logic w_last;
  logic w_start;

  assign in_ready = (r_state == WRITE);
  assign busy     = (r_state != IDLE);
  assign w_beat   = in_valid & in_ready;
  assign w_last   = (r_cnt == ADDR_W'(DEPTH - 1));
  assign w_start  = (r_state == IDLE) & start_w;

`ifdef RAM_WRITER_VERIFY_EN
  logic              r_rd_pend;
  logic [DATA_W-1:0] r_chk_r;

  // A read issued by the address register lands on mem_douta one cycle after the RAM samples it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_pend <= 1'b0;
      r_chk_r   <= '0;
    end else begin
      r_rd_pend <= r_mem_ena & ~r_mem_wea;
      if (w_start)
        r_chk_r <= '0;
      else if (r_rd_pend)
        r_chk_r <= r_chk_r ^ mem_douta;
    end
  end
`else
  logic w_unused;
  assign w_unused = ^{mem_douta, r_chk_w};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_done       <= 1'b0;
      r_verify_err <= 1'b0;
      r_mem_ena    <= 1'b0;
      r_mem_wea    <= 1'b0;
      r_mem_addra  <= '0;
      r_mem_dina   <= '0;
      r_chk_w      <= '0;
    end else begin
      r_done    <= 1'b0;
      r_mem_ena <= 1'b0;
      r_mem_wea <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start_w) begin
            r_state      <= WRITE;
            r_cnt        <= '0;
            r_chk_w      <= '0;
            r_verify_err <= 1'b0;
          end
        end
        WRITE: begin
          if (w_beat) begin
            r_mem_ena   <= 1'b1;
            r_mem_wea   <= 1'b1;
            r_mem_addra <= r_cnt;
            r_mem_dina  <= in_data;
            r_chk_w     <= r_chk_w ^ in_data;
            if (w_last) begin
              r_cnt   <= '0;
              r_state <= FLUSH;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        FLUSH: begin
`ifdef RAM_WRITER_VERIFY_EN
          r_state <= VERIFY;
`else
          r_state <= FIN;
`endif
        end
`ifdef RAM_WRITER_VERIFY_EN
        VERIFY: begin
          r_mem_ena   <= 1'b1;
          r_mem_addra <= r_cnt;
          if (w_last) begin
            r_cnt   <= '0;
            r_state <= CHECK;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        CHECK: begin
          // Both the last issued read and its fold must have drained before comparing.
          if (!r_mem_ena && !r_rd_pend) begin
            r_verify_err <= (r_chk_r != r_chk_w);
            r_state      <= FIN;
          end
        end
`endif
        FIN: begin
          r_done  <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign done       = r_done;
  assign verify_err = r_verify_err;
  assign mem_ena    = r_mem_ena;
  assign mem_wea    = r_mem_wea;
  assign mem_addra  = r_mem_addra;
  assign mem_dina   = r_mem_dina;

endmodule
